// File: rtl/imem_load_ctrl.sv
// Instruction memory port sequencer: host program loader, pipelined fetch, halt.
// Optional halt-opcode detection is enabled with IMEM_HALT_DETECT_EN.
module imem_load_ctrl #(
  parameter int          DEPTH    = 200,
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] NOP_WORD = 32'hFC010820
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              ld_err,
  output logic [ADDR_W-1:0] ld_count,
  input  logic              run_start,
  input  logic              run_stop,
  output logic              core_run,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              fetch_oor,
  output logic              mem_w_en,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_datain,
  input  logic [31:0]       mem_dataout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic              ld_ready_q, ld_ready_d;
  logic              ld_err_q, ld_err_d;
  logic [ADDR_W-1:0] ld_count_q, ld_count_d;
  logic              core_run_q, core_run_d;
  logic              f1_vld_q, f1_vld_d;
  logic              f1_oor_q, f1_oor_d;
  logic [31:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_oor_q, fetch_oor_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic              mem_mode_q, mem_mode_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_datain_q, mem_datain_d;

  logic ld_accept;
  logic halt_hit;

  assign ld_accept = ld_valid & ld_ready_q;

`ifdef IMEM_HALT_DETECT_EN
  assign halt_hit = instr_valid_q & (instr_q[31:26] == 6'b111111);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    ld_ready_d    = ld_ready_q;
    ld_err_d      = ld_err_q;
    ld_count_d    = ld_count_q;
    f1_vld_d      = 1'b0;
    f1_oor_d      = 1'b0;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fetch_oor_d   = 1'b0;
    mem_w_en_d    = 1'b0;
    mem_mode_d    = 1'b1;
    mem_addr_d    = mem_addr_q;
    mem_datain_d  = mem_datain_q;

    // core_run_q mirrors state RUN, so fetch and load never share a cycle
    if (core_run_q && fetch_req) begin
      f1_vld_d = 1'b1;
      if (fetch_pc < DEPTH_A) begin
        mem_addr_d = fetch_pc;
      end else begin
        f1_oor_d = 1'b1;
      end
    end

    if (f1_vld_q) begin
      instr_valid_d = 1'b1;
      fetch_oor_d   = f1_oor_q;
      instr_d       = f1_oor_q ? NOP_WORD : mem_dataout;
    end

    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d    = S_LOAD;
          wp_d       = '0;
          ld_ready_d = 1'b1;
          ld_err_d   = 1'b0;
        end else if (run_start) begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (ld_accept) begin
          mem_w_en_d   = 1'b1;
          mem_mode_d   = 1'b0;
          mem_addr_d   = wp_q;
          mem_datain_d = ld_data;
          wp_d         = wp_q + 1'b1;
          if (ld_last) begin
            state_d    = S_IDLE;
            ld_ready_d = 1'b0;
            ld_count_d = wp_q + 1'b1;
          end else if (wp_q == LAST_A) begin
            state_d    = S_IDLE;
            ld_ready_d = 1'b0;
            ld_err_d   = 1'b1;
            ld_count_d = DEPTH_A;
          end
        end
      end
      S_RUN: begin
        if (run_stop) begin
          state_d = S_IDLE;
        end else if (halt_hit) begin
          state_d = S_HALT;
        end
      end
`ifdef IMEM_HALT_DETECT_EN
      S_HALT: begin
        if (ld_start) begin
          state_d    = S_LOAD;
          wp_d       = '0;
          ld_ready_d = 1'b1;
          ld_err_d   = 1'b0;
        end else if (run_start) begin
          state_d = S_RUN;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    core_run_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wp_q          <= '0;
      ld_ready_q    <= 1'b0;
      ld_err_q      <= 1'b0;
      ld_count_q    <= '0;
      core_run_q    <= 1'b0;
      f1_vld_q      <= 1'b0;
      f1_oor_q      <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_oor_q   <= 1'b0;
      mem_w_en_q    <= 1'b0;
      mem_mode_q    <= 1'b1;
      mem_addr_q    <= '0;
      mem_datain_q  <= '0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      ld_ready_q    <= ld_ready_d;
      ld_err_q      <= ld_err_d;
      ld_count_q    <= ld_count_d;
      core_run_q    <= core_run_d;
      f1_vld_q      <= f1_vld_d;
      f1_oor_q      <= f1_oor_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_oor_q   <= fetch_oor_d;
      mem_w_en_q    <= mem_w_en_d;
      mem_mode_q    <= mem_mode_d;
      mem_addr_q    <= mem_addr_d;
      mem_datain_q  <= mem_datain_d;
    end
  end

  assign ld_ready    = ld_ready_q;
  assign ld_err      = ld_err_q;
  assign ld_count    = ld_count_q;
  assign core_run    = core_run_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_oor   = fetch_oor_q;
  assign mem_w_en    = mem_w_en_q;
  assign mem_mode    = mem_mode_q;
  assign mem_addr    = mem_addr_q;
  assign mem_datain  = mem_datain_q;

endmodule
